axil_irq_timer: RTL and testbench
=================================

// Module: axil_irq_timer
// PURPOSE
// - AXI4-Lite slave timer on the PS M_AXI_GP0 port, downstream of the Zynq PS in the system block design.
// - 32-bit up-counter with compare match, one-shot/auto-reload modes and a level interrupt to PS IRQ_F2P[0].
// - Gives the PS a cycle-accurate PL time base and periodic interrupt source.
// PARAMETERS
// - ADDR_W   6             byte-address width of AXI-Lite window (64 B)
// - ID_VALUE 32'h504D_5401 constant returned by ID register
// PORTS
// - axi_aclk      in   1   single clock (FCLK_CLK0); all logic on rising edge
// - axi_aresetn   in   1   asynchronous assert, active-low reset
// - s_axi_aw*     in/out   awaddr[ADDR_W], awvalid, awready
// - s_axi_w*      in/out   wdata[32], wstrb[4], wvalid, wready
// - s_axi_b*      in/out   bresp[2], bvalid, bready
// - s_axi_ar*     in/out   araddr[ADDR_W], arvalid, arready
// - s_axi_r*      in/out   rdata[32], rresp[2], rvalid, rready
// - irq           out  1   level interrupt = STATUS.match & CTRL.irq_en, registered
// BEHAVIOUR
// - Reset: all ready/valid low, bresp/rresp 0, rdata 0, irq 0, all registers 0 except ID.
// - Write: awready/wready pulse together for 1 cycle only when awvalid & wvalid & !bvalid; bvalid next cycle,
//   held until bready; one outstanding write. wstrb honoured per byte; bresp always OKAY.
// - Read: arready pulses 1 cycle when arvalid & !rvalid; rdata/rvalid next cycle, held until rready; rresp OKAY.
// - Map: 0x00 CTRL [0]enable [1]auto_reload [2]irq_en [3]clr (write-1 pulse, reads 0)
//        0x04 STATUS [0]match, W1C   0x08 COUNT RO   0x0C COMPARE RW   0x10 PRESCALE RW (see CONFIG)
//        0x14 ID RO = ID_VALUE; unmapped reads 0, unmapped/RO writes ignored, both OKAY.
// - tick: every cycle without prescaler; count advances when enable & tick.
// - Match: when enable & tick & count==COMPARE: STATUS.match<=1;
//   auto_reload=1 -> count<=0, stays enabled; auto_reload=0 -> count holds COMPARE, CTRL.enable<=0 (one-shot).
// - No match: count<=count+1, wraps 0xFFFF_FFFF -> 0 silently (no flag).
// - COMPARE=0 with auto_reload: match on every tick, count stays 0.
// - clr write: count<=0 next cycle; takes priority over increment/reload same cycle; match detection that cycle
//   still sets STATUS.match.
// - Simultaneous HW match set and SW W1C of match: set wins.
// - irq registered: asserts 1 cycle after match flag sets (if irq_en), deasserts 1 cycle after W1C or irq_en=0.
// - Writing COMPARE while running takes effect on the next tick's comparison.
// - Reset mid-transaction: handshake abandoned, all valids drop immediately (async), registers to reset values.
// CONFIGURATION
// - Macro AXIL_TIMER_PRESCALE_EN:
//   defined   -> 16-bit PRESCALE reg at 0x10 (low 16 bits RW); tick pulses once every PRESCALE+1 cycles
//                from internal divider, divider cleared by clr and when enable=0.
//   undefined -> tick=1 every cycle; 0x10 reads 0, writes ignored; no divider logic.
// STRUCTURE
// - Package axil_timer_pkg: register offset localparams, CTRL/STATUS bit index constants, ID default,
//   typedef struct packed ctrl_t {clr, irq_en, auto_reload, enable}.
// - Sub-module tick_gen (prescale divider, present only under AXIL_TIMER_PRESCALE_EN).
// - Top holds AXI-Lite handshake FSMs (write: IDLE->RESP; read: IDLE->DATA) and counter/regs.
// TESTING
// - Reset then read ID 0x14 -> rdata 0x504D5401, rresp 0; read 0x08 -> 0; irq 0.
// - COMPARE=9, CTRL=0x7 -> match 10 ticks after enable, count->0, irq high next cycle, repeats every 10 ticks.
// - COMPARE=4, CTRL=0x5 (one-shot) -> count holds 4, CTRL reads 0x4, STATUS=1; W1C STATUS -> irq low next cycle.
// - Write awvalid with wvalid delayed 3 cycles, bready held low 5 cycles -> no accept until wvalid, bvalid held,
//   no second write accepted meanwhile.
// - W1C STATUS in same cycle as HW match -> STATUS stays 1; clr with match same cycle -> count 0, STATUS 1.
// - PRESCALE_EN: PRESCALE=3, COMPARE=1, CTRL=0x3 -> match every 8 cycles; without macro 0x10 reads 0.

Source files
------------

// File: rtl/axil_irq_timer_pkg.sv
// -----------------------------------------------------------------------------
// axil_timer_pkg
// Shared definitions for the AXI4-Lite interrupt timer:
//   - register byte offsets inside the 64 B window
//   - CTRL / STATUS bit positions
//   - default ID register value
//   - ctrl_t layout of the CTRL register
//   - handshake FSM state enums
//   - byte-strobe merge helper
// Optional feature macro used by the design: AXIL_TIMER_PRESCALE_EN
// -----------------------------------------------------------------------------
package axil_timer_pkg;

  localparam logic [7:0] CTRL_OFF     = 8'h00;
  localparam logic [7:0] STATUS_OFF   = 8'h04;
  localparam logic [7:0] COUNT_OFF    = 8'h08;
  localparam logic [7:0] COMPARE_OFF  = 8'h0C;
  localparam logic [7:0] PRESCALE_OFF = 8'h10;
  localparam logic [7:0] ID_OFF       = 8'h14;

  localparam int CTRL_ENABLE_BIT      = 0;
  localparam int CTRL_AUTO_RELOAD_BIT = 1;
  localparam int CTRL_IRQ_EN_BIT      = 2;
  localparam int CTRL_CLR_BIT         = 3;
  localparam int STATUS_MATCH_BIT     = 0;

  localparam logic [31:0] ID_DEFAULT = 32'h504D_5401;
  localparam logic [1:0]  RESP_OKAY  = 2'b00;

  // Bit 3 down to bit 0 of CTRL; clr is a write pulse and is never stored as 1
  typedef struct packed {
    logic clr;
    logic irq_en;
    logic auto_reload;
    logic enable;
  } ctrl_t;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  // Replace only the bytes whose strobe bit is set
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_val[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axil_irq_timer_if.sv
// -----------------------------------------------------------------------------
// axil_irq_timer_if
// AXI4-Lite bus bundle for the interrupt timer.
//   AW: awaddr[ADDR_W], awvalid, awready
//   W : wdata[32], wstrb[4], wvalid, wready
//   B : bresp[2], bvalid, bready
//   AR: araddr[ADDR_W], arvalid, arready
//   R : rdata[32], rresp[2], rvalid, rready
// Modports: master (PS side) and slave (timer side).
// -----------------------------------------------------------------------------
interface axil_irq_timer_if #(
  parameter int ADDR_W = 6
) ();

  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axil_irq_timer_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Prescale divider for the interrupt timer; only built with AXIL_TIMER_PRESCALE_EN.
//   clk      in   timer clock
//   rst_n    in   asynchronous active-low reset
//   enable   in   CTRL.enable; divider is held at 0 while low
//   clr      in   CTRL.clr write pulse; restarts the divider
//   prescale in   16-bit divide value, tick every prescale+1 cycles
//   tick     out  one-cycle advance strobe for the counter
// -----------------------------------------------------------------------------
`ifdef AXIL_TIMER_PRESCALE_EN
module tick_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        clr,
  input  logic [15:0] prescale,
  output logic        tick
);

  logic [15:0] div;

  assign tick = enable && (div == prescale);

  // Divider restarts whenever the timer is stopped or cleared so the first
  // tick after enabling always lands a full prescale period later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (!enable || clr || tick) begin
      div <= '0;
    end else begin
      div <= div + 16'd1;
    end
  end

endmodule
`endif

// File: rtl/axil_irq_timer.sv
// -----------------------------------------------------------------------------
// axil_irq_timer
// AXI4-Lite slave timer: 32-bit up-counter with compare match, one-shot or
// auto-reload operation and a registered level interrupt.
//   axi_aclk     in   clock, all logic on rising edge
//   axi_aresetn  in   asynchronous active-low reset
//   s_axi        slave modport of axil_irq_timer_if (AW/W/B/AR/R channels)
//   irq          out  STATUS.match & CTRL.irq_en, registered
// Optional feature macro: AXIL_TIMER_PRESCALE_EN (PRESCALE register + divider)
// -----------------------------------------------------------------------------
module axil_irq_timer
  import axil_timer_pkg::*;
#(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] ID_VALUE = ID_DEFAULT
) (
  input  logic                axi_aclk,
  input  logic                axi_aresetn,
  axil_irq_timer_if.slave     s_axi,
  output logic                irq
);

  wr_state_t wr_state, wr_state_nxt;
  rd_state_t rd_state, rd_state_nxt;
  logic              wr_accept, rd_accept;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [31:0]       rd_mux, rdata_q;

  ctrl_t       ctrl;
  logic        status_match;
  logic [31:0] count, compare, prescale_rd;
  logic        tick, tick_en, match_hit;
  logic        wr_ctrl, wr_status, wr_compare, clr_req, w1c_match;

  function automatic logic addr_hit(input logic [ADDR_W-1:0] a, input logic [7:0] off);
    return a == ADDR_W'(off);
  endfunction

  assign wr_addr = s_axi.awaddr;
  assign rd_addr = s_axi.araddr;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
    end else begin
      wr_state <= wr_state_nxt;
      rd_state <= rd_state_nxt;
    end
  end

  // Address and data are taken together, and only while no response is pending
  always_comb begin
    wr_state_nxt = wr_state;
    wr_accept    = 1'b0;
    case (wr_state)
      W_IDLE: if (s_axi.awvalid && s_axi.wvalid) begin
        wr_accept    = 1'b1;
        wr_state_nxt = W_RESP;
      end
      W_RESP: if (s_axi.bready) wr_state_nxt = W_IDLE;
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_nxt = rd_state;
    rd_accept    = 1'b0;
    case (rd_state)
      R_IDLE: if (s_axi.arvalid) begin
        rd_accept    = 1'b1;
        rd_state_nxt = R_DATA;
      end
      R_DATA: if (s_axi.rready) rd_state_nxt = R_IDLE;
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  assign s_axi.awready = wr_accept;
  assign s_axi.wready  = wr_accept;
  assign s_axi.bvalid  = (wr_state == W_RESP);
  assign s_axi.bresp   = RESP_OKAY;
  assign s_axi.arready = rd_accept;
  assign s_axi.rvalid  = (rd_state == R_DATA);
  assign s_axi.rresp   = RESP_OKAY;
  assign s_axi.rdata   = rdata_q;

  assign wr_ctrl    = wr_accept && addr_hit(wr_addr, CTRL_OFF) && s_axi.wstrb[0];
  assign wr_status  = wr_accept && addr_hit(wr_addr, STATUS_OFF) && s_axi.wstrb[0];
  assign wr_compare = wr_accept && addr_hit(wr_addr, COMPARE_OFF);
  assign clr_req    = wr_ctrl && s_axi.wdata[CTRL_CLR_BIT];
  assign w1c_match  = wr_status && s_axi.wdata[STATUS_MATCH_BIT];

`ifdef AXIL_TIMER_PRESCALE_EN
  logic [15:0] prescale;
  logic        wr_prescale;

  assign wr_prescale = wr_accept && addr_hit(wr_addr, PRESCALE_OFF);
  assign prescale_rd = {16'b0, prescale};

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      prescale <= '0;
    end else if (wr_prescale) begin
      if (s_axi.wstrb[0]) prescale[7:0]  <= s_axi.wdata[7:0];
      if (s_axi.wstrb[1]) prescale[15:8] <= s_axi.wdata[15:8];
    end
  end

  tick_gen u_tick_gen (
    .clk      (axi_aclk),
    .rst_n    (axi_aresetn),
    .enable   (ctrl.enable),
    .clr      (clr_req),
    .prescale (prescale),
    .tick     (tick)
  );
`else
  assign tick        = 1'b1;
  assign prescale_rd = '0;
`endif

  assign tick_en   = ctrl.enable && tick;
  assign match_hit = tick_en && (count == compare);

  always_comb begin
    rd_mux = '0;
    if (addr_hit(rd_addr, CTRL_OFF))          rd_mux = {28'b0, ctrl};
    else if (addr_hit(rd_addr, STATUS_OFF))   rd_mux = {31'b0, status_match};
    else if (addr_hit(rd_addr, COUNT_OFF))    rd_mux = count;
    else if (addr_hit(rd_addr, COMPARE_OFF))  rd_mux = compare;
    else if (addr_hit(rd_addr, PRESCALE_OFF)) rd_mux = prescale_rd;
    else if (addr_hit(rd_addr, ID_OFF))       rd_mux = ID_VALUE;
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      rdata_q <= '0;
    end else if (rd_accept) begin
      rdata_q <= rd_mux;
    end
  end

  // Counter and registers. clr beats increment/reload, a hardware match beats
  // a same-cycle W1C, and a one-shot match clears enable even if software
  // writes CTRL in that same cycle.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      ctrl         <= '0;
      status_match <= 1'b0;
      count        <= '0;
      compare      <= '0;
      irq          <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl.enable      <= s_axi.wdata[CTRL_ENABLE_BIT];
        ctrl.auto_reload <= s_axi.wdata[CTRL_AUTO_RELOAD_BIT];
        ctrl.irq_en      <= s_axi.wdata[CTRL_IRQ_EN_BIT];
      end
      ctrl.clr <= 1'b0;
      if (match_hit && !ctrl.auto_reload) ctrl.enable <= 1'b0;

      if (wr_compare) compare <= apply_wstrb(compare, s_axi.wdata, s_axi.wstrb);

      if (clr_req)        count <= '0;
      else if (match_hit) count <= ctrl.auto_reload ? '0 : count;
      else if (tick_en)   count <= count + 32'd1;

      if (match_hit)      status_match <= 1'b1;
      else if (w1c_match) status_match <= 1'b0;

      irq <= status_match && ctrl.irq_en;
    end
  end

endmodule

// File: tb/tb_axil_irq_timer.sv
// -----------------------------------------------------------------------------
// tb_axil_irq_timer
// Directed self-checking bench for axil_irq_timer. Expected values are
// hand-computed from the register map and counter timing. The prescale
// scenario follows AXIL_TIMER_PRESCALE_EN.
// -----------------------------------------------------------------------------
module tb_axil_irq_timer;

  logic clk = 1'b0;
  logic rst_n;
  logic irq;
  int   checks   = 0;
  int   failures = 0;

  axil_irq_timer_if #(.ADDR_W(6)) bus ();

  axil_irq_timer #(.ADDR_W(6), .ID_VALUE(32'h504D_5401)) dut (
    .axi_aclk    (clk),
    .axi_aresetn (rst_n),
    .s_axi       (bus),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  // One comparison: count it, report it when it differs
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // AXI-Lite write; called at a negedge, returns at a negedge one cycle after B completes
  task automatic applyStimulus(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    bus.awaddr  = addr;
    bus.awvalid = 1'b1;
    bus.wdata   = data;
    bus.wstrb   = strb;
    bus.wvalid  = 1'b1;
    #1;
    n = 0;
    while (!(bus.awready && bus.wready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) checkOutput("aw_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b1;
    #1;
    n = 0;
    while (!bus.bvalid && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) checkOutput("b_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.bready = 1'b0;
  endtask

  task automatic axil_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    #1;
    n = 0;
    while (!bus.arready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) checkOutput("ar_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    #1;
    n = 0;
    while (!bus.rvalid && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) checkOutput("r_timeout", 32'd0, 32'd1);
    data = bus.rdata;
    resp = bus.rresp;
    @(posedge clk);
    @(negedge clk);
    bus.rready = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [5:0] addr, input logic [31:0] expected);
    logic [31:0] d;
    logic [1:0]  r;
    axil_read(addr, d, r);
    checkOutput(tag, d, expected);
  endtask

  // Negedges until irq is seen high, bounded
  task automatic wait_irq(output int n);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (irq) break;
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          n;
    logic        seen;
    logic        held;

    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_bvalid", 32'(bus.bvalid), 32'd0);
    checkOutput("rst_rvalid", 32'(bus.rvalid), 32'd0);
    checkOutput("rst_rdata", bus.rdata, 32'd0);
    checkOutput("rst_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ID, COUNT after reset
    axil_read(6'h14, d, r);
    checkOutput("id", d, 32'h504D_5401);
    checkOutput("id_rresp", 32'(r), 32'd0);
    read_check("count_rst", 6'h08, 32'd0);

    // Auto-reload: COMPARE=9, CTRL=0x7
    applyStimulus(6'h0C, 32'd9, 4'hF);
    applyStimulus(6'h00, 32'h7, 4'hF);
    wait_irq(n);
    checkOutput("auto_first_irq_delay", 32'(n), 32'd10);
    read_check("auto_count_after_wrap", 6'h08, 32'd1);
    applyStimulus(6'h04, 32'h1, 4'hF);
    checkOutput("auto_irq_cleared", 32'(irq), 32'd0);
    wait_irq(n);
    checkOutput("auto_second_irq_delay", 32'(n), 32'd6);

    // One-shot: COMPARE=4, CTRL=0x5
    applyStimulus(6'h00, 32'h8, 4'hF);
    applyStimulus(6'h04, 32'h1, 4'hF);
    applyStimulus(6'h0C, 32'd4, 4'hF);
    applyStimulus(6'h00, 32'h5, 4'hF);
    repeat (15) @(negedge clk);
    read_check("oneshot_count", 6'h08, 32'd4);
    read_check("oneshot_ctrl", 6'h00, 32'h4);
    read_check("oneshot_status", 6'h04, 32'h1);
    checkOutput("oneshot_irq", 32'(irq), 32'd1);
    applyStimulus(6'h04, 32'h1, 4'hF);
    checkOutput("oneshot_irq_w1c", 32'(irq), 32'd0);

    // Delayed wvalid and stalled bready
    bus.awaddr = 6'h0C; bus.awvalid = 1'b1; bus.wdata = 32'h55; bus.wstrb = 4'hF; bus.wvalid = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      #1; if (bus.awready || bus.wready) seen = 1'b1;
      @(negedge clk);
    end
    checkOutput("hs_no_accept_without_w", 32'(seen), 32'd0);
    bus.wvalid = 1'b1;
    #1;
    checkOutput("hs_accept", 32'({bus.awready, bus.wready}), 32'd3);
    @(posedge clk);
    @(negedge clk);
    bus.wdata = 32'hAA;
    seen = 1'b0;
    held = 1'b1;
    repeat (5) begin
      #1;
      if (bus.awready || bus.wready) seen = 1'b1;
      if (!bus.bvalid) held = 1'b0;
      @(negedge clk);
    end
    checkOutput("hs_no_second_accept", 32'(seen), 32'd0);
    checkOutput("hs_bvalid_held", 32'(held), 32'd1);
    checkOutput("hs_bresp", 32'(bus.bresp), 32'd0);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.bready = 1'b0;
    checkOutput("hs_bvalid_drop", 32'(bus.bvalid), 32'd0);
    read_check("hs_compare", 6'h0C, 32'h55);
    applyStimulus(6'h0C, 32'hFFFF_FFFF, 4'b0101);
    read_check("wstrb_compare", 6'h0C, 32'h00FF_00FF);

    // COMPARE=0 auto-reload: W1C racing a match, clr racing a match
    applyStimulus(6'h00, 32'h8, 4'hF);
    applyStimulus(6'h0C, 32'd0, 4'hF);
    applyStimulus(6'h00, 32'h7, 4'hF);
    applyStimulus(6'h04, 32'h1, 4'hF);
    checkOutput("w1c_vs_match_irq", 32'(irq), 32'd1);
    read_check("w1c_vs_match_status", 6'h04, 32'h1);
    applyStimulus(6'h00, 32'hF, 4'hF);
    read_check("clr_match_count", 6'h08, 32'd0);
    read_check("clr_match_status", 6'h04, 32'h1);
    read_check("ctrl_clr_reads0", 6'h00, 32'h7);

    // Unmapped and read-only locations
    applyStimulus(6'h14, 32'h0, 4'hF);
    read_check("id_ro", 6'h14, 32'h504D_5401);
    read_check("unmapped_18", 6'h18, 32'd0);
    read_check("unmapped_3c", 6'h3C, 32'd0);

    // Prescaler
    applyStimulus(6'h00, 32'h8, 4'hF);
    applyStimulus(6'h04, 32'h1, 4'hF);
`ifdef AXIL_TIMER_PRESCALE_EN
    applyStimulus(6'h10, 32'd3, 4'hF);
    read_check("prescale_rw", 6'h10, 32'd3);
    applyStimulus(6'h0C, 32'd1, 4'hF);
    applyStimulus(6'h00, 32'h7, 4'hF);
    wait_irq(n);
    checkOutput("prescale_first_irq", 32'(n), 32'd8);
    applyStimulus(6'h04, 32'h1, 4'hF);
    checkOutput("prescale_irq_cleared", 32'(irq), 32'd0);
    wait_irq(n);
    checkOutput("prescale_second_irq", 32'(n), 32'd6);
`else
    applyStimulus(6'h10, 32'd3, 4'hF);
    read_check("prescale_absent", 6'h10, 32'd0);
`endif

    // Reset during an open read response
    applyStimulus(6'h0C, 32'h1234, 4'hF);
    bus.araddr = 6'h0C; bus.arvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.arvalid = 1'b0;
    checkOutput("mid_rvalid_before", 32'(bus.rvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rvalid_dropped", 32'(bus.rvalid), 32'd0);
    checkOutput("mid_rdata_cleared", bus.rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    read_check("mid_compare_reset", 6'h0C, 32'd0);
    read_check("mid_ctrl_reset", 6'h00, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
